// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB definitions: instruction op encoding, controller states and the
// TLBIDX CSR field layout, plus the CSR write-back record.
package tlb_op_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_SRCH = 3'd0,
      OP_RD   = 3'd1,
      OP_WR   = 3'd2,
      OP_FILL = 3'd3,
      OP_INV  = 3'd4
   } tlb_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } tlb_state_e;

   // TLBIDX: NE at bit 31, PS at 29:24, INDEX at 4:0
   localparam int TLBIDX_NE     = 31;
   localparam int TLBIDX_PS_HI  = 29;
   localparam int TLBIDX_PS_LO  = 24;
   localparam int TLBIDX_IDX_HI = 4;
   localparam int TLBIDX_IDX_LO = 0;
   localparam int TLBIDX_IDX_W  = TLBIDX_IDX_HI - TLBIDX_IDX_LO + 1;

   typedef struct packed {
      logic [31:0] tlbidx;
      logic [31:0] tlbehi;
      logic [31:0] tlbelo0;
      logic [31:0] tlbelo1;
      logic [9:0]  asid;
   } tlb_resp_t;

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequences one TLB instruction at a time: latches operands, strobes the TLB
// for one cycle, samples the TLB result and returns the CSR write-back values.
module tlb_op_ctrl
   import tlb_op_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [2:0]              req_op,
   input  logic [4:0]              req_inv_op,
   input  logic [9:0]              req_inv_asid,
   input  logic [18:0]             req_inv_vpn,
   input  logic                    flush,
   input  logic [31:0]             csr_tlbehi,
   input  logic [31:0]             csr_tlbelo0,
   input  logic [31:0]             csr_tlbelo1,
   input  logic [31:0]             csr_tlbidx,
   input  logic [9:0]              csr_asid,
   input  logic [5:0]              csr_ecode,
   output logic                    tlbsrch_en,
   output logic                    tlbwr_en,
   output logic                    tlbfill_en,
   output logic                    invtlb_en,
   output logic [31:0]             tlbsrch_ehi,
   output logic [31:0]             tlbehi_in,
   output logic [31:0]             tlbelo0_in,
   output logic [31:0]             tlbelo1_in,
   output logic [31:0]             tlbidx_in,
   output logic [TLBIDX_IDX_W-1:0] rand_index,
   output logic [5:0]              ecode_in,
   output logic [4:0]              invtlb_op,
   output logic [9:0]              invtlb_asid,
   output logic [18:0]             invtlb_vpn,
   input  logic                    search_tlb_found,
   input  logic [TLBIDX_IDX_W-1:0] search_tlb_index,
   input  logic [31:0]             tlbehi_out,
   input  logic [31:0]             tlbelo0_out,
   input  logic [31:0]             tlbelo1_out,
   input  logic [31:0]             tlbidx_out,
   input  logic [9:0]              asid_out,
   output logic                    resp_valid,
   output logic [2:0]              resp_op,
   output logic [31:0]             resp_tlbidx,
   output logic [31:0]             resp_tlbehi,
   output logic [31:0]             resp_tlbelo0,
   output logic [31:0]             resp_tlbelo1,
   output logic [9:0]              resp_asid
);

   tlb_state_e                state_q;
   logic [TLBIDX_IDX_W-1:0]   rand_cnt;
   logic [2:0]                op_p0;
   logic [4:0]                inv_op_p0;
   logic [9:0]                inv_asid_p0;
   logic [18:0]               inv_vpn_p0;
   logic [31:0]               ehi_p0;
   logic [31:0]               elo0_p0;
   logic [31:0]               elo1_p0;
   logic [31:0]               idx_p0;
   logic [9:0]                asid_p0;
   logic [5:0]                ecode_p0;
   logic [TLBIDX_IDX_W-1:0]   rand_p0;
   tlb_resp_t                 resp_p2;
   logic                      accept;
   logic                      issue_live;
   logic                      unused_bits;

   // Builds the CSR write-back; illegal and write-type ops return all zero.
   function automatic tlb_resp_t form_resp(
      input logic [2:0]              op,
      input logic [31:0]             csr_idx,
      input logic                    found,
      input logic [TLBIDX_IDX_W-1:0] index,
      input logic [31:TLBIDX_PS_LO]  rd_idx_hi,
      input logic [31:0]             rd_ehi,
      input logic [31:0]             rd_elo0,
      input logic [31:0]             rd_elo1,
      input logic [9:0]              rd_asid
   );
      tlb_resp_t r;
      r = '0;
      case (op)
         OP_SRCH: begin
            if (found)
               r.tlbidx = {1'b0, csr_idx[TLBIDX_NE-1:TLBIDX_IDX_HI+1], index};
            else
               r.tlbidx = {1'b1, csr_idx[TLBIDX_NE-1:0]};
         end
         OP_RD: begin
            r.tlbidx = {rd_idx_hi[TLBIDX_NE:TLBIDX_PS_HI+1],
                        rd_idx_hi[TLBIDX_PS_HI:TLBIDX_PS_LO],
                        csr_idx[TLBIDX_PS_LO-1:0]};
            if (!rd_idx_hi[TLBIDX_NE]) begin
               r.tlbehi  = rd_ehi;
               r.tlbelo0 = rd_elo0;
               r.tlbelo1 = rd_elo1;
               r.asid    = rd_asid;
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   assign req_ready = (state_q == ST_IDLE) && !flush;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rand_cnt    <= '0;
         op_p0       <= '0;
         inv_op_p0   <= '0;
         inv_asid_p0 <= '0;
         inv_vpn_p0  <= '0;
         ehi_p0      <= '0;
         elo0_p0     <= '0;
         elo1_p0     <= '0;
         idx_p0      <= '0;
         asid_p0     <= '0;
         ecode_p0    <= '0;
         rand_p0     <= '0;
         resp_p2     <= '0;
      end else begin
         rand_cnt <= rand_cnt + 1'b1;
         case (state_q)
            // p0: operand capture on acceptance
            ST_IDLE: begin
               if (accept) begin
                  op_p0       <= req_op;
                  inv_op_p0   <= req_inv_op;
                  inv_asid_p0 <= req_inv_asid;
                  inv_vpn_p0  <= req_inv_vpn;
                  ehi_p0      <= csr_tlbehi;
                  elo0_p0     <= csr_tlbelo0;
                  elo1_p0     <= csr_tlbelo1;
                  idx_p0      <= csr_tlbidx;
                  asid_p0     <= csr_asid;
                  ecode_p0    <= csr_ecode;
                  rand_p0     <= rand_cnt;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: state_q <= flush ? ST_IDLE : ST_WAIT;
            // p2: TLB result sampled while tlbidx_in is still presented
            ST_WAIT: begin
               if (flush) begin
                  state_q <= ST_IDLE;
               end else begin
                  resp_p2 <= form_resp(op_p0, idx_p0, search_tlb_found,
                                       search_tlb_index,
                                       tlbidx_out[31:TLBIDX_PS_LO],
                                       tlbehi_out, tlbelo0_out,
                                       tlbelo1_out, asid_out);
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Strobes and resp_valid are gated late so a flush or reset in the same cycle kills them.
   assign issue_live = (state_q == ST_ISSUE) && !flush && !reset;
   assign tlbsrch_en = issue_live && (op_p0 == OP_SRCH);
   assign tlbwr_en   = issue_live && (op_p0 == OP_WR);
   assign tlbfill_en = issue_live && (op_p0 == OP_FILL);
   assign invtlb_en  = issue_live && (op_p0 == OP_INV);

   assign tlbsrch_ehi = ehi_p0;
   assign tlbehi_in   = ehi_p0;
   assign tlbelo0_in  = elo0_p0;
   assign tlbelo1_in  = elo1_p0;
   assign tlbidx_in   = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? idx_p0 : '0;
   assign rand_index  = rand_p0;
   assign ecode_in    = ecode_p0;
   assign invtlb_op   = inv_op_p0;
   assign invtlb_asid = inv_asid_p0;
   assign invtlb_vpn  = inv_vpn_p0;

   assign resp_valid   = (state_q == ST_RESP) && !flush && !reset;
   assign resp_op      = op_p0;
   assign resp_tlbidx  = resp_p2.tlbidx;
   assign resp_tlbehi  = resp_p2.tlbehi;
   assign resp_tlbelo0 = resp_p2.tlbelo0;
   assign resp_tlbelo1 = resp_p2.tlbelo1;
   assign resp_asid    = resp_p2.asid;

   // The current ASID is latched with the other CSRs but the TLB port carries it in tlbehi context only.
   assign unused_bits = ^{tlbidx_out[TLBIDX_PS_LO-1:0], asid_p0};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: a vector table covering every op plus
// hand-written sequences for counter timing, flush, reset and throughput.
module tb_tlb_op_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [4:0]  req_inv_op = 5'd3;
   logic [9:0]  req_inv_asid = 10'h2A5;
   logic [18:0] req_inv_vpn = 19'h5_1234;
   logic        flush = 1'b0;
   logic [31:0] csr_tlbehi = 32'h1234_6000;
   logic [31:0] csr_tlbelo0 = 32'hAAAA_0001;
   logic [31:0] csr_tlbelo1 = 32'h5555_0002;
   logic [31:0] csr_tlbidx = '0;
   logic [9:0]  csr_asid = 10'h07;
   logic [5:0]  csr_ecode = 6'h3F;
   logic        tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en;
   logic [31:0] tlbsrch_ehi, tlbehi_in, tlbelo0_in, tlbelo1_in, tlbidx_in;
   logic [4:0]  rand_index;
   logic [5:0]  ecode_in;
   logic [4:0]  invtlb_op;
   logic [9:0]  invtlb_asid;
   logic [18:0] invtlb_vpn;
   logic        search_tlb_found = 1'b0;
   logic [4:0]  search_tlb_index = '0;
   logic [31:0] tlbehi_out = '0, tlbelo0_out = '0, tlbelo1_out = '0, tlbidx_out = '0;
   logic [9:0]  asid_out = '0;
   logic        resp_valid;
   logic [2:0]  resp_op;
   logic [31:0] resp_tlbidx, resp_tlbehi, resp_tlbelo0, resp_tlbelo1;
   logic [9:0]  resp_asid;

   tlb_op_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vpn(req_inv_vpn),
      .flush(flush),
      .csr_tlbehi(csr_tlbehi), .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1),
      .csr_tlbidx(csr_tlbidx), .csr_asid(csr_asid), .csr_ecode(csr_ecode),
      .tlbsrch_en(tlbsrch_en), .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en), .invtlb_en(invtlb_en),
      .tlbsrch_ehi(tlbsrch_ehi), .tlbehi_in(tlbehi_in), .tlbelo0_in(tlbelo0_in),
      .tlbelo1_in(tlbelo1_in), .tlbidx_in(tlbidx_in), .rand_index(rand_index), .ecode_in(ecode_in),
      .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn),
      .search_tlb_found(search_tlb_found), .search_tlb_index(search_tlb_index),
      .tlbehi_out(tlbehi_out), .tlbelo0_out(tlbelo0_out), .tlbelo1_out(tlbelo1_out),
      .tlbidx_out(tlbidx_out), .asid_out(asid_out),
      .resp_valid(resp_valid), .resp_op(resp_op), .resp_tlbidx(resp_tlbidx),
      .resp_tlbehi(resp_tlbehi), .resp_tlbelo0(resp_tlbelo0), .resp_tlbelo1(resp_tlbelo1),
      .resp_asid(resp_asid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] c_idx;
      logic        found;
      logic [4:0]  sidx;
      logic [31:0] o_idx, o_ehi, o_elo0, o_elo1;
      logic [9:0]  o_asid;
      logic [3:0]  e_strb;
      logic [31:0] e_idx, e_ehi, e_elo0, e_elo1;
      logic [9:0]  e_asid;
   } vec_t;

   vec_t vecs[10];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] c_idx,
                               input logic found, input logic [4:0] sidx,
                               input logic [31:0] o_idx, input logic [31:0] o_ehi,
                               input logic [3:0] e_strb, input logic [31:0] e_idx,
                               input logic pass_rd);
      vec_t v;
      v.op = op; v.c_idx = c_idx; v.found = found; v.sidx = sidx;
      v.o_idx = o_idx; v.o_ehi = o_ehi;
      v.o_elo0 = 32'h1111_1111; v.o_elo1 = 32'h2222_2222; v.o_asid = 10'h155;
      v.e_strb = e_strb; v.e_idx = e_idx;
      v.e_ehi  = pass_rd ? o_ehi : 32'h0;
      v.e_elo0 = pass_rd ? 32'h1111_1111 : 32'h0;
      v.e_elo1 = pass_rd ? 32'h2222_2222 : 32'h0;
      v.e_asid = pass_rd ? 10'h155 : 10'h0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic logic [3:0] strb();
      return {tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(3'd0, 32'h8C00_0000, 1'b1, 5'd5,  32'h1234_5678, 32'hDEAD_BEEF, 4'b1000, 32'h0C00_0005, 1'b0);
      vecs[1] = mk(3'd0, 32'h0C00_0003, 1'b0, 5'd5,  32'h1234_5678, 32'hDEAD_BEEF, 4'b1000, 32'h8C00_0003, 1'b0);
      vecs[2] = mk(3'd1, 32'h00AB_CDEF, 1'b1, 5'd9,  32'h0C00_0000, 32'h0000_4000, 4'b0000, 32'h0CAB_CDEF, 1'b1);
      vecs[3] = mk(3'd1, 32'h3F00_0000, 1'b1, 5'd9,  32'h8000_0000, 32'h0000_4000, 4'b0000, 32'h8000_0000, 1'b0);
      vecs[4] = mk(3'd1, 32'h0065_4321, 1'b0, 5'd1,  32'hBF12_3456, 32'h0000_8000, 4'b0000, 32'hBF65_4321, 1'b0);
      vecs[5] = mk(3'd2, 32'h0000_0011, 1'b1, 5'd9,  32'h1234_5678, 32'hDEAD_BEEF, 4'b0100, 32'h0, 1'b0);
      vecs[6] = mk(3'd3, 32'h0000_0012, 1'b1, 5'd9,  32'h1234_5678, 32'hDEAD_BEEF, 4'b0010, 32'h0, 1'b0);
      vecs[7] = mk(3'd4, 32'h0000_0013, 1'b1, 5'd9,  32'h1234_5678, 32'hDEAD_BEEF, 4'b0001, 32'h0, 1'b0);
      vecs[8] = mk(3'd6, 32'h8C00_0000, 1'b1, 5'd9,  32'h0C00_0000, 32'hDEAD_BEEF, 4'b0000, 32'h0, 1'b0);
      vecs[9] = mk(3'd7, 32'h8C00_0000, 1'b1, 5'd9,  32'h0C00_0000, 32'hDEAD_BEEF, 4'b0000, 32'h0, 1'b0);

      // Reset, then cycle 0 is the first cycle with reset low.
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      cyc = 0;
      smp();
      chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_strobes", {28'b0, strb()}, 32'h0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      chk("rst_tlbidx_in", tlbidx_in, 32'h0);
      chk("rst_tlbehi_in", tlbehi_in, 32'h0);
      chk("rst_rand_index", {27'b0, rand_index}, 32'h0);
      chk("rst_resp_tlbidx", resp_tlbidx, 32'h0);
      chk("rst_invtlb_op", {27'b0, invtlb_op}, 32'h0);

      // FILL accepted at cycle 7
      while (cyc < 7) tick();
      req_valid = 1'b1; req_op = 3'd3;
      tick();
      req_valid = 1'b0;
      smp();
      chk("fill7_strobe", {28'b0, strb()}, 32'h2);
      chk("fill7_rand_index", {27'b0, rand_index}, 32'd7);
      chk("fill7_resp_early", {31'b0, resp_valid}, 32'h0);
      tick(); smp();
      chk("fill7_strobe_off", {31'b0, tlbfill_en}, 32'h0);
      tick(); smp();
      chk("fill7_resp_t3", {31'b0, resp_valid}, 32'h1);
      chk("fill7_resp_op", {29'b0, resp_op}, 32'd3);
      tick(); smp();
      chk("fill7_resp_off", {31'b0, resp_valid}, 32'h0);

      // FILL accepted at cycle 35: counter has wrapped to 3
      while (cyc < 35) tick();
      req_valid = 1'b1; req_op = 3'd3;
      tick();
      req_valid = 1'b0;
      smp();
      chk("fill35_rand_index", {27'b0, rand_index}, 32'd3);
      repeat (3) tick();

      // Table-driven op coverage
      for (int i = 0; i < 10; i++) begin
         req_op = vecs[i].op; csr_tlbidx = vecs[i].c_idx;
         search_tlb_found = vecs[i].found; search_tlb_index = vecs[i].sidx;
         tlbidx_out = vecs[i].o_idx; tlbehi_out = vecs[i].o_ehi;
         tlbelo0_out = vecs[i].o_elo0; tlbelo1_out = vecs[i].o_elo1; asid_out = vecs[i].o_asid;
         req_valid = 1'b1;
         smp();
         chk($sformatf("v%0d_ready_idle", i), {31'b0, req_ready}, 32'h1);
         tick();
         req_valid = 1'b0;
         smp();
         chk($sformatf("v%0d_strobe", i), {28'b0, strb()}, {28'b0, vecs[i].e_strb});
         chk($sformatf("v%0d_tlbidx_in_issue", i), tlbidx_in, vecs[i].c_idx);
         chk($sformatf("v%0d_tlbehi_in", i), tlbehi_in, 32'h1234_6000);
         chk($sformatf("v%0d_elo1_in", i), tlbelo1_in, 32'h5555_0002);
         chk($sformatf("v%0d_ecode_in", i), {26'b0, ecode_in}, 32'h3F);
         chk($sformatf("v%0d_inv_ops", i), {invtlb_op, invtlb_asid, invtlb_vpn}, {5'd3, 10'h2A5, 19'h5_1234} & 32'hFFFF_FFFF);
         chk($sformatf("v%0d_ready_busy", i), {31'b0, req_ready}, 32'h0);
         tick(); smp();
         chk($sformatf("v%0d_strobe_wait", i), {28'b0, strb()}, 32'h0);
         chk($sformatf("v%0d_tlbidx_in_wait", i), tlbidx_in, vecs[i].c_idx);
         tick(); smp();
         chk($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid}, 32'h1);
         chk($sformatf("v%0d_resp_op", i), {29'b0, resp_op}, {29'b0, vecs[i].op});
         chk($sformatf("v%0d_resp_tlbidx", i), resp_tlbidx, vecs[i].e_idx);
         chk($sformatf("v%0d_resp_tlbehi", i), resp_tlbehi, vecs[i].e_ehi);
         chk($sformatf("v%0d_resp_tlbelo0", i), resp_tlbelo0, vecs[i].e_elo0);
         chk($sformatf("v%0d_resp_tlbelo1", i), resp_tlbelo1, vecs[i].e_elo1);
         chk($sformatf("v%0d_resp_asid", i), {22'b0, resp_asid}, {22'b0, vecs[i].e_asid});
         tick();
      end

      // Flush in ISSUE for WR
      begin
         logic seen;
         req_valid = 1'b1; req_op = 3'd2;
         tick();
         req_valid = 1'b0; flush = 1'b1;
         smp();
         chk("flush_issue_wr_en", {31'b0, tlbwr_en}, 32'h0);
         tick();
         flush = 1'b0;
         smp();
         chk("flush_issue_ready", {31'b0, req_ready}, 32'h1);
         seen = 1'b0;
         for (int k = 0; k < 4; k++) begin
            seen = seen | resp_valid | tlbwr_en;
            tick(); smp();
         end
         chk("flush_issue_quiet", {31'b0, seen}, 32'h0);
      end

      // Flush in WAIT
      req_valid = 1'b1; req_op = 3'd0;
      tick(); req_valid = 1'b0;
      tick(); flush = 1'b1;
      tick(); flush = 1'b0;
      smp();
      chk("flush_wait_ready", {31'b0, req_ready}, 32'h1);
      chk("flush_wait_resp", {31'b0, resp_valid}, 32'h0);

      // Flush in RESP
      req_valid = 1'b1; req_op = 3'd0;
      tick(); req_valid = 1'b0;
      tick(); tick();
      flush = 1'b1;
      smp();
      chk("flush_resp_valid", {31'b0, resp_valid}, 32'h0);
      tick(); flush = 1'b0;
      smp();
      chk("flush_resp_ready", {31'b0, req_ready}, 32'h1);

      // Flush coinciding with req_valid in IDLE
      flush = 1'b1; req_valid = 1'b1; req_op = 3'd0;
      smp();
      chk("flush_idle_ready", {31'b0, req_ready}, 32'h0);
      tick();
      flush = 1'b0; req_valid = 1'b0;
      smp();
      chk("flush_idle_no_strobe", {31'b0, tlbsrch_en}, 32'h0);
      chk("flush_idle_still_idle", {31'b0, req_ready}, 32'h1);

      // Back-to-back: req_valid held high for 8 cycles
      begin
         int n_strb, n_resp, n_rdy;
         n_strb = 0; n_resp = 0; n_rdy = 0;
         req_valid = 1'b1; req_op = 3'd0;
         for (int k = 0; k < 8; k++) begin
            tick(); smp();
            n_strb += int'(tlbsrch_en);
            n_resp += int'(resp_valid);
            n_rdy  += int'(req_ready);
         end
         req_valid = 1'b0;
         chk("b2b_strobes", n_strb, 32'd2);
         chk("b2b_resps", n_resp, 32'd2);
         chk("b2b_ready", n_rdy, 32'd2);
         tick();
      end

      // Reset pulsed in ISSUE for WR: strobe killed in that cycle
      req_valid = 1'b1; req_op = 3'd2;
      tick(); req_valid = 1'b0; reset = 1'b1;
      smp();
      chk("rst_issue_wr_en", {31'b0, tlbwr_en}, 32'h0);
      tick(); reset = 1'b0;

      // Reset pulsed in WAIT for INV
      req_valid = 1'b1; req_op = 3'd4;
      tick(); req_valid = 1'b0;
      smp();
      chk("rst_wait_inv_strobe", {31'b0, invtlb_en}, 32'h1);
      tick(); reset = 1'b1;
      smp();
      chk("rst_wait_resp_during", {31'b0, resp_valid}, 32'h0);
      tick(); reset = 1'b0;
      smp();
      chk("rst_wait_idle", {31'b0, req_ready}, 32'h1);
      chk("rst_wait_resp_after", {31'b0, resp_valid}, 32'h0);
      chk("rst_wait_inv_op_clr", {27'b0, invtlb_op}, 32'h0);
      tick(); smp();
      chk("rst_wait_resp_later", {31'b0, resp_valid}, 32'h0);
      chk("rst_wait_no_strobe", {28'b0, strb()}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have clk  input  1  clock; all logic on posedge clk.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have req_valid / req_ready  input / output  1  TLB-instruction handshake from the execute stage.
REQ-004 SHALL have req_op  input  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 are illegal.
REQ-005 SHALL have req_inv_op, req_inv_asid, req_inv_vpn  input  5/10/19  INVTLB operands.
REQ-006 SHALL have flush  input  1  pipeline flush.
REQ-007 SHALL have csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_tlbidx  input  32 each  current CSR values.
REQ-008 SHALL have csr_asid  input  10, and csr_ecode  input  6 (ESTAT.Ecode).
REQ-009 SHALL have tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en  output  1 each  TLB command strobes.
REQ-010 SHALL have tlbsrch_ehi, tlbehi_in, tlbelo0_in, tlbelo1_in, tlbidx_in  output  32 each; rand_index  output  5; ecode_in  output  6.
REQ-011 SHALL have invtlb_op, invtlb_asid, invtlb_vpn  output  5/10/19.
REQ-012 SHALL have search_tlb_found / search_tlb_index  input  1/5; tlbehi_out, tlbelo0_out, tlbelo1_out, tlbidx_out  input  32 each; asid_out  input  10.
REQ-013 SHALL have resp_valid  output  1; resp_op  output  3; resp_tlbidx, resp_tlbehi, resp_tlbelo0, resp_tlbelo1  output  32 each; resp_asid  output  10 (CSR write-back).

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one cycle per state.
REQ-015 SHALL assert req_ready only in IDLE with flush=0; acceptance = req_valid && req_ready.
REQ-016 SHALL, on acceptance, register req_op, INV operands, all csr_* inputs, and rand_cnt.
REQ-017 SHALL, for an illegal req_op, accept the request, issue no strobe, and return resp_valid with all resp_* data zero.
REQ-018 SHALL, in ISSUE, pulse exactly one strobe for exactly one cycle: SRCH->tlbsrch_en, RD->none, WR->tlbwr_en, FILL->tlbfill_en, INV->invtlb_en.
REQ-019 SHALL drive tlbidx_in from the registered csr_tlbidx in ISSUE and WAIT, so RD data returns in WAIT; all other operand outputs SHALL be valid in ISSUE.
REQ-020 SHALL sample search_tlb_* and the *_out buses in WAIT.
REQ-021 SHALL, in RESP, assert resp_valid for one cycle; first request accepted at cycle T gives resp_valid at T+3.
REQ-022 SHALL form the SRCH result as: found -> resp_tlbidx = {0, csr_tlbidx[30:5], index}; not found -> resp_tlbidx = {1, csr_tlbidx[30:0]}.
REQ-023 SHALL form the RD result as resp_tlbidx = {tlbidx_out[31:24], csr_tlbidx[23:0]}; if tlbidx_out[31]=1, resp_tlbehi, resp_tlbelo0, resp_tlbelo1 and resp_asid SHALL be 0, else they pass the returned values.
REQ-024 SHALL return zero data for WR, FILL and INV, with resp_op valid.
REQ-025 SHALL keep rand_cnt, a 5-bit free-running counter incremented every cycle and wrapping 31->0, as the rand_index source.
REQ-026 SHALL handle flush by state: ISSUE suppresses the strobe and goes to IDLE; WAIT or RESP suppresses resp_valid and goes to IDLE.
REQ-027 SHALL, when flush and req_valid coincide in IDLE, not accept the request.
REQ-028 SHALL accept back-to-back requests at most once every 4 cycles.

Reset
REQ-029 SHALL, on reset, force state=IDLE, rand_cnt=0, all strobes=0, resp_valid=0, and all data outputs=0.
REQ-030 SHALL, on reset mid-operation, abort the operation with no strobe and no response in the following cycle.

Structure
REQ-031 SHALL place the op encoding enum, the FSM state enum and the TLBIDX field positions (NE=31, PS=29:24, INDEX=4:0) in the shared TLB package.
REQ-032 SHALL be a single module; the FSM and the datapath stay together.

Verification
REQ-033 SRCH hit: search_tlb_found=1, index=5, csr_tlbidx=0x8C000000 -> resp_tlbidx=0x0C000005 at T+3.
REQ-034 SRCH miss: csr_tlbidx=0x0C000003 -> resp_tlbidx=0x8C000003.
REQ-035 RD: tlbidx_out=0x0C000000, tlbehi_out=0x00004000 -> resp_tlbehi=0x00004000, resp_tlbidx[23:0]=csr_tlbidx[23:0]; repeat with tlbidx_out=0x80000000 -> all data zero.
REQ-036 FILL accepted at cycle 7 after reset -> tlbfill_en high for exactly one cycle at cycle 8, rand_index=7; wrap checked at cycle 35 -> 3.
REQ-037 flush asserted in ISSUE for WR -> tlbwr_en never asserted, no resp_valid, req_ready high the next cycle.
REQ-038 reset pulsed in WAIT for INV -> resp_valid=0 and state IDLE afterwards; illegal op 6 -> resp_valid with zero data.
